// File: rtl/spi_master_tx.sv
// spi_master_tx: mode-0, MSB-first SPI transmitter that sends one DATA_W-bit
// word per ssn-low window. The frame is built from CLK_DIV-cycle half periods:
// one setup half, DATA_W high/low pairs, then a 2*CLK_DIV idle gap with ssn
// high so the downstream receiver can finish its post-frame work.
module spi_master_tx #(
    parameter int CLK_DIV = 5,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic              ssn,
    output logic              sclk,
    output logic              mosi
);

    if (CLK_DIV < 3) begin : g_bad_clk_div
        $error("spi_master_tx: CLK_DIV must be at least 3");
    end
    if (DATA_W < 2) begin : g_bad_data_w
        $error("spi_master_tx: DATA_W must be at least 2");
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              last_q, last_d;          // final bit is in its hold phase
    logic              gap_second_q, gap_second_d; // second half of the gap
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ssn_q, ssn_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              div_end_s;

    assign div_end_s = (div_cnt_q == DIV_LAST);

    assign busy = busy_q;
    assign done = done_q;
    assign ssn  = ssn_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: every non-idle state advances on half-period expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SETUP;
                else       state_d = ST_IDLE;
            end
            ST_SETUP: begin
                if (div_end_s) state_d = ST_SHIFT_HI;
                else           state_d = ST_SETUP;
            end
            ST_SHIFT_HI: begin
                if (div_end_s) state_d = ST_SHIFT_LO;
                else           state_d = ST_SHIFT_HI;
            end
            ST_SHIFT_LO: begin
                if (div_end_s) begin
                    if (last_q) state_d = ST_GAP;
                    else        state_d = ST_SHIFT_HI;
                end else begin
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_GAP: begin
                if (div_end_s && gap_second_q) state_d = ST_IDLE;
                else                           state_d = ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; all pins change only at state boundaries.
    always_comb begin
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        last_d       = last_q;
        gap_second_d = gap_second_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ssn_d        = ssn_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;

        if (state_q == ST_IDLE) begin
            div_cnt_d = {DIV_W{1'b0}};
        end else if (div_end_s) begin
            div_cnt_d = {DIV_W{1'b0}};
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d      = tx_data;
                    bit_cnt_d    = {BIT_W{1'b0}};
                    last_d       = 1'b0;
                    gap_second_d = 1'b0;
                    ssn_d        = 1'b0;
                    mosi_d       = tx_data[DATA_W-1];
                    busy_d       = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (div_end_s) sclk_d = 1'b1;
                else           sclk_d = 1'b0;
            end
            ST_SHIFT_HI: begin
                if (div_end_s) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q < BIT_LAST) begin
                        // Rotating keeps every register bit in use; bits that
                        // wrap to the bottom are never presented on mosi.
                        shreg_d   = {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
                        mosi_d    = shreg_q[DATA_W-2];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end else begin
                        last_d = 1'b1;
                    end
                end else begin
                    sclk_d = 1'b1;
                end
            end
            ST_SHIFT_LO: begin
                if (div_end_s) begin
                    if (last_q) begin
                        ssn_d        = 1'b1;
                        mosi_d       = 1'b0;
                        gap_second_d = 1'b0;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end else begin
                    sclk_d = 1'b0;
                end
            end
            ST_GAP: begin
                if (div_end_s) begin
                    if (gap_second_q) begin
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        last_d       = 1'b0;
                        gap_second_d = 1'b0;
                        bit_cnt_d    = {BIT_W{1'b0}};
                    end else begin
                        gap_second_d = 1'b1;
                    end
                end else begin
                    gap_second_d = gap_second_q;
                end
            end
            default: begin
                ssn_d  = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset returns pins to the idle bus state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q    <= {DIV_W{1'b0}};
            bit_cnt_q    <= {BIT_W{1'b0}};
            shreg_q      <= {DATA_W{1'b0}};
            last_q       <= 1'b0;
            gap_second_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ssn_q        <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            last_q       <= last_d;
            gap_second_q <= gap_second_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ssn_q        <= ssn_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: three instances (CLK_DIV 5, 3, 8) compared cycle by
// cycle against an arithmetic frame model, plus word reassembly on sclk rises.
module tb_spi_master_tx;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v [3];
    logic [15:0] txd_v   [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        ssn_v   [3];
    logic        sclk_v  [3];
    logic        mosi_v  [3];

    int n_cmp   = 0;
    int n_fail  = 0;
    int gap_run = 0;

    always #5 clk = ~clk;

    spi_master_tx #(.CLK_DIV(5), .DATA_W(W)) u_dut (
        .clk(clk), .reset(reset), .start(start_v[0]), .tx_data(txd_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .ssn(ssn_v[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0])
    );
    spi_master_tx #(.CLK_DIV(3), .DATA_W(W)) u_div3 (
        .clk(clk), .reset(reset), .start(start_v[1]), .tx_data(txd_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .ssn(ssn_v[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1])
    );
    spi_master_tx #(.CLK_DIV(8), .DATA_W(W)) u_div8 (
        .clk(clk), .reset(reset), .start(start_v[2]), .tx_data(txd_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .ssn(ssn_v[2]), .sclk(sclk_v[2]), .mosi(mosi_v[2])
    );

    function automatic int div_of(input int sel);
        if (sel == 1)      return 3;
        else if (sel == 2) return 8;
        else               return 5;
    endfunction

    // Expected {ssn,sclk,mosi,busy,done} t edges after the accepting edge.
    function automatic logic [4:0] model(input int t, input int d_div, input logic [15:0] d);
        int  idx;
        logic e_ssn, e_sclk, e_mosi, e_busy, e_done;
        if (t < 0) return 5'b10000;
        e_ssn  = (t < (2*W+1)*d_div) ? 1'b0 : 1'b1;
        e_sclk = (t >= d_div && t < (2*W+1)*d_div && ((t / d_div) % 2 == 1)) ? 1'b1 : 1'b0;
        if (t < (2*W+1)*d_div) begin
            idx = t / (2*d_div);
            if (idx > W-1) idx = W-1;
            e_mosi = d[W-1-idx];
        end else begin
            e_mosi = 1'b0;
        end
        e_busy = (t < (2*W+3)*d_div) ? 1'b1 : 1'b0;
        e_done = (t == (2*W+3)*d_div) ? 1'b1 : 1'b0;
        return {e_ssn, e_sclk, e_mosi, e_busy, e_done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int sel, input logic [4:0] exp);
        check($sformatf("%s.ssn[%0d]", tag, sel),  32'(ssn_v[sel]),  32'(exp[4]));
        check($sformatf("%s.sclk[%0d]", tag, sel), 32'(sclk_v[sel]), 32'(exp[3]));
        check($sformatf("%s.mosi[%0d]", tag, sel), 32'(mosi_v[sel]), 32'(exp[2]));
        check($sformatf("%s.busy[%0d]", tag, sel), 32'(busy_v[sel]), 32'(exp[1]));
        check($sformatf("%s.done[%0d]", tag, sel), 32'(done_v[sel]), 32'(exp[0]));
    endtask

    task automatic idle_cycles(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_outs("idle", sel, 5'b10000);
        end
    endtask

    // One frame: start is raised now, accepted at the next edge (t=0).
    // poke_t pulses a competing start with new data; rst_t aborts via reset.
    task automatic run_frame(input int sel, input logic [15:0] d, input int poke_t,
                             input int rst_t, input bit chk_gap);
        int          d_div;
        int          t_end;
        logic [15:0] rx;
        int          rises;
        int          ssn_low;
        int          dones;
        logic        prev_sclk;
        d_div     = div_of(sel);
        t_end     = (2*W+3)*d_div;
        rx        = 16'h0000;
        rises     = 0;
        ssn_low   = 0;
        dones     = 0;
        prev_sclk = 1'b0;
        start_v[sel] = 1'b1;
        txd_v[sel]   = d;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        txd_v[sel]   = 16'($urandom);
        for (int t = 0; t <= t_end; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            check_outs("frame", sel, model(t, d_div, d));
            if (sclk_v[sel] && !prev_sclk) begin
                rx = {rx[14:0], mosi_v[sel]};
                rises++;
            end
            prev_sclk = sclk_v[sel];
            if (!ssn_v[sel]) ssn_low++;
            if (done_v[sel]) dones++;
            if (t == 0 && chk_gap) check("gap_ge_10", 32'(gap_run >= 10), 32'd1);
            if (ssn_v[sel]) gap_run++;
            else            gap_run = 0;
            if (t == poke_t) begin
                start_v[sel] = 1'b1;
                txd_v[sel]   = 16'hBEEF;
            end
            if (t == poke_t + 1) start_v[sel] = 1'b0;
            if (t == rst_t) begin
                reset = 1'b1;
                #1;
                check_outs("rst_abort", sel, 5'b10000);
                return;
            end
        end
        check($sformatf("rx_word[%0d]", sel), 32'(rx), 32'(d));
        check($sformatf("rises[%0d]", sel), rises, W);
        check($sformatf("ssn_low[%0d]", sel), ssn_low, (2*W+1)*d_div);
        check($sformatf("dones[%0d]", sel), dones, 1);
    endtask

    logic [15:0] words [8];

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            txd_v[i]   = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_outs("reset", i, 5'b10000);
        reset = 1'b0;
        idle_cycles(0, 2);

        // Single frame
        run_frame(0, 16'hA5C3, -1, -1, 1'b0);
        idle_cycles(0, 5);

        // Back-to-back loopback: start raised in each done cycle
        words[0] = 16'h0001;
        words[1] = 16'h8000;
        words[2] = 16'hFFFF;
        words[3] = 16'h0000;
        for (int i = 4; i < 8; i++) words[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) run_frame(0, words[i], -1, -1, (i > 0));
        idle_cycles(0, 5);

        // Busy rejection: second start at E0+40 must be dropped
        run_frame(0, 16'h1234, 40, -1, 1'b0);
        idle_cycles(0, 20);

        // Reset mid-frame at E0+80, then a clean frame
        run_frame(0, 16'($urandom), -1, 80, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(0, 200);
        run_frame(0, 16'h5A5A, -1, -1, 1'b0);

        // Divider sweep
        run_frame(1, 16'hC0DE, -1, -1, 1'b0);
        run_frame(2, 16'hC0DE, -1, -1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_frame(1, 16'($urandom), -1, -1, 1'b0);
            run_frame(2, 16'($urandom), -1, -1, 1'b0);
        end

        // Long idle
        idle_cycles(0, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
